mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 1024x64 synchronous scratchpad between two requesters: port 0 (RoCC command path) and port 1 (DMA/refill engine).
- Each requester has a valid/ready request channel and a response channel.
- Grants at most one request per cycle, round-robin, and drives the memory port.
- Reads have a fixed 1-cycle memory latency; read data is routed back to the issuing port.
- Flags protocol anomalies with a sticky error bit.

Parameters:
ADDR_W, 10, memory word-address width (depth = 2**ADDR_W)
DATA_W, 64, data word width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
p0_req_valid  in  1  port 0 request valid
p0_req_ready  out  1  port 0 request accepted this cycle
p0_req_wren  in  1  1 = write, 0 = read
p0_req_addr  in  ADDR_W  word address
p0_req_wrdata  in  DATA_W  write data
p0_resp_valid  out  1  port 0 read data valid (single-cycle pulse)
p0_resp_data  out  DATA_W  port 0 read data
p1_req_valid, p1_req_ready, p1_req_wren, p1_req_addr, p1_req_wrdata, p1_resp_valid, p1_resp_data: same widths and meanings as port 0, for port 1
mem_rqvalid  out  1  read request to memory
mem_wren  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wrdata  out  DATA_W  memory write data
mem_rdvalid  in  1  memory read data valid, exactly 1 cycle after mem_rqvalid
mem_rddata  in  DATA_W  memory read data
err_sticky  out  1  set on unexpected mem_rdvalid; cleared only by reset

Behaviour:
- State: rr_ptr (1 bit, port with priority this cycle), pend_vld (1 bit), pend_owner (1 bit), err_sticky.
- Reset values: rr_ptr=0, pend_vld=0, pend_owner=0, err_sticky=0.
- Reset effect on outputs: pX_resp_valid=0, pX_resp_data=0, pX_req_ready=0, mem_rqvalid=0, mem_wren=0.
- Arbitration (combinational):
  - If exactly one port is valid, it wins.
  - If both are valid, port rr_ptr wins.
  - pX_req_ready = grant to X; ready may depend on valid. Requesters must hold valid and payload stable until ready.
- Handshake: a request is accepted in any cycle where valid & ready. No request is accepted while reset is high.
- Memory drive (combinational from the winning port):
  - mem_addr = winner's addr.
  - mem_wrdata = winner's wrdata.
  - mem_wren = grant & wren.
  - mem_rqvalid = grant & ~wren. Writes never assert mem_rqvalid.
  - With no grant: addr/wrdata are don't-care, both enables are 0.
- rr_ptr update: on any grant, rr_ptr <= ~winner. Otherwise unchanged. This gives strict alternation under continuous contention.
- Read tracking:
  - On a read grant: pend_vld <= 1, pend_owner <= winner.
  - On a cycle with no read grant: pend_vld <= 0.
  - Back-to-back reads issue every cycle; this is a 1-deep pipeline, not a blocking transaction.
- Response:
  - In a cycle with mem_rdvalid & pend_vld: p[pend_owner]_resp_valid=1 and p[pend_owner]_resp_data=mem_rddata. These are combinational pass-through, so total read latency is 1 cycle after acceptance.
  - The other port's resp_valid is 0.
  - Each pX_resp_data is held at its last delivered value when idle. This requires one registered copy per port.
- Error:
  - mem_rdvalid without pend_vld -> err_sticky <= 1; the data is dropped.
  - pend_vld without mem_rdvalid -> err_sticky <= 1; no response is produced.
- Ordering and hazards:
  - A write followed by a read to the same address the next cycle returns the new data.
  - No same-cycle read and write is possible (one grant per cycle).
- Reset mid-operation: any pending read is discarded and no response is delivered after reset deasserts.
- Address wrap: none. Addresses map 1:1, with no range check.

Decomposition:
- Shared package (mem_arb_pkg):
  - ADDR_W and DATA_W defaults.
  - Port-index localparams PORT0=0, PORT1=1.
- One natural sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: valid[1:0], rr_ptr.
  - Outputs: grant[1:0], winner.
  - Reusable for other shared-resource controllers.
- Response routing and pending tracking stay in the top level.

Test Plan:
- Single read: p0 write addr 5 data 0xDEAD_BEEF, then p0 read addr 5 -> p0_req_ready=1 on each, p0_resp_valid pulses 1 cycle after read acceptance with 0xDEAD_BEEF, p1_resp_valid stays 0.
- Contention: p0 and p1 both hold valid reads (addrs 1 and 2) for 4 cycles after reset -> grant order p0,p1,p0,p1; responses alternate p0,p1,p0,p1 each 1 cycle after grant with correct data.
- Back-to-back hazard: p1 writes 0x1234 to addr 1023, p1 reads addr 1023 the next cycle -> 0x1234 returned; mem_rqvalid never high during a write cycle.
- Mixed traffic: p0 write and p1 read contending, rr_ptr=1 -> p1 granted first, p0 next cycle; only p1_resp_valid pulses.
- Reset mid-read: assert reset in the cycle after a read grant -> no resp_valid on either port after reset release; rr_ptr=0; err_sticky=0.
- Anomaly: force mem_rdvalid=1 with no outstanding read -> err_sticky=1 next cycle, stays 1 until reset; no resp_valid asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the scratchpad port arbiter: default widths and port indices.
package mem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to rr_ptr.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr_ptr;
      default: winner = 1'b0;
    endcase
    grant = 2'b00;
    if (|valid) grant = winner ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port scratchpad between a RoCC port (0) and a DMA port (1),
// routing 1-cycle read data back to the issuing port and flagging protocol anomalies.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_wren,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wrdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_data,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_wren,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wrdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_data,

  output logic              mem_rqvalid,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic              mem_rdvalid,
  input  logic [DATA_W-1:0] mem_rddata,

  output logic              err_sticky
);

  logic [1:0]        req_vld;
  logic [1:0]        grant;
  logic              winner;
  logic              any_grant;
  logic              win_wren;
  logic              rr_ptr;
  logic              pend_vld;
  logic              pend_owner;
  logic              resp_fire;
  logic [DATA_W-1:0] p0_hold;
  logic [DATA_W-1:0] p1_hold;

  // Masking valid with reset keeps ready and both memory enables low while in reset.
  assign req_vld = {p1_req_valid, p0_req_valid} & {2{~reset}};

  rr_arb2 u_rr_arb2 (
    .valid  (req_vld),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign any_grant    = |grant;
  assign p0_req_ready = grant[PORT0];
  assign p1_req_ready = grant[PORT1];

  always_comb begin
    mem_addr   = p0_req_addr;
    mem_wrdata = p0_req_wrdata;
    win_wren   = p0_req_wren;
    if (winner == PORT1) begin
      mem_addr   = p1_req_addr;
      mem_wrdata = p1_req_wrdata;
      win_wren   = p1_req_wren;
    end
  end

  assign mem_wren    = any_grant & win_wren;
  assign mem_rqvalid = any_grant & ~win_wren;

  // Read data passes straight through to the owner; the hold registers cover idle cycles.
  assign resp_fire     = mem_rdvalid & pend_vld;
  assign p0_resp_valid = resp_fire & (pend_owner == PORT0);
  assign p1_resp_valid = resp_fire & (pend_owner == PORT1);
  assign p0_resp_data  = p0_resp_valid ? mem_rddata : p0_hold;
  assign p1_resp_data  = p1_resp_valid ? mem_rddata : p1_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_owner <= 1'b0;
      err_sticky <= 1'b0;
      p0_hold    <= '0;
      p1_hold    <= '0;
    end else begin
      if (any_grant) rr_ptr <= ~winner;
      pend_vld <= mem_rqvalid;
      if (mem_rqvalid) pend_owner <= winner;
      if (p0_resp_valid) p0_hold <= mem_rddata;
      if (p1_resp_valid) p1_hold <= mem_rddata;
      // Data without a pending read, or a pending read without data, both count.
      if (mem_rdvalid != pend_vld) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural scratchpad, shadow memory and a response scoreboard.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid = 1'b0, p0_req_wren = 1'b0;
  logic [9:0]  p0_req_addr = '0;
  logic [63:0] p0_req_wrdata = '0;
  logic        p0_req_ready, p0_resp_valid;
  logic [63:0] p0_resp_data;
  logic        p1_req_valid = 1'b0, p1_req_wren = 1'b0;
  logic [9:0]  p1_req_addr = '0;
  logic [63:0] p1_req_wrdata = '0;
  logic        p1_req_ready, p1_resp_valid;
  logic [63:0] p1_resp_data;
  logic        mem_rqvalid, mem_wren, mem_rdvalid;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wrdata;
  logic [63:0] mem_rddata = '0;
  logic        mdl_rdvalid = 1'b0;
  logic        inj_rdvalid = 1'b0;
  logic        err_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        port;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mem_arr [0:1023];
  logic [63:0] shadow  [0:1023];
  logic [63:0] last0 = '0;
  logic [63:0] last1 = '0;

  assign mem_rdvalid = mdl_rdvalid | inj_rdvalid;

  mem_port_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .p0_req_valid  (p0_req_valid),
    .p0_req_ready  (p0_req_ready),
    .p0_req_wren   (p0_req_wren),
    .p0_req_addr   (p0_req_addr),
    .p0_req_wrdata (p0_req_wrdata),
    .p0_resp_valid (p0_resp_valid),
    .p0_resp_data  (p0_resp_data),
    .p1_req_valid  (p1_req_valid),
    .p1_req_ready  (p1_req_ready),
    .p1_req_wren   (p1_req_wren),
    .p1_req_addr   (p1_req_addr),
    .p1_req_wrdata (p1_req_wrdata),
    .p1_resp_valid (p1_resp_valid),
    .p1_resp_data  (p1_resp_data),
    .mem_rqvalid   (mem_rqvalid),
    .mem_wren      (mem_wren),
    .mem_addr      (mem_addr),
    .mem_wrdata    (mem_wrdata),
    .mem_rdvalid   (mem_rdvalid),
    .mem_rddata    (mem_rddata),
    .err_sticky    (err_sticky)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port scratchpad with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_wren) mem_arr[mem_addr] <= mem_wrdata;
    if (mem_rqvalid) mem_rddata <= mem_arr[mem_addr];
    mdl_rdvalid <= mem_rqvalid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic accept(input logic port, input logic wren, input logic [9:0] addr,
                        input logic [63:0] data);
    exp_t e;
    chk("mem_addr", mem_addr, addr);
    chk("mem_wren", mem_wren, wren);
    chk("mem_rqvalid", mem_rqvalid, !wren);
    if (wren) begin
      shadow[addr] = data;
    end else begin
      e.port = port;
      e.data = shadow[addr];
      e.due  = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: responses are checked before this cycle's accepts are recorded.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (p0_resp_valid || p1_resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", {p1_resp_valid, p0_resp_valid}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("resp_port", {p1_resp_valid, p0_resp_valid}, e.port ? 2'b10 : 2'b01);
          chk("resp_data", e.port ? p1_resp_data : p0_resp_data, e.data);
          chk("resp_latency", cyc, e.due);
          if (e.port) last1 = e.data;
          else last0 = e.data;
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk("resp_missing", 1'b0, 1'b1);
      end
      if (!p0_resp_valid) chk("p0_hold", p0_resp_data, last0);
      if (!p1_resp_valid) chk("p1_hold", p1_resp_data, last1);
      chk("one_grant", p0_req_ready & p1_req_ready, 1'b0);
      if (p0_req_valid && p0_req_ready) accept(1'b0, p0_req_wren, p0_req_addr, p0_req_wrdata);
      if (p1_req_valid && p1_req_ready) accept(1'b1, p1_req_wren, p1_req_addr, p1_req_wrdata);
      if (!p0_req_ready && !p1_req_ready) chk("mem_idle", {mem_rqvalid, mem_wren}, 2'b00);
    end
  end

  task automatic set_port(input logic port, input logic vld, input logic wren,
                          input logic [9:0] addr, input logic [63:0] data);
    if (port) begin
      p1_req_valid = vld; p1_req_wren = wren; p1_req_addr = addr; p1_req_wrdata = data;
    end else begin
      p0_req_valid = vld; p0_req_wren = wren; p0_req_addr = addr; p0_req_wrdata = data;
    end
  endtask

  task automatic do_req(input logic port, input logic wren, input logic [9:0] addr,
                        input logic [63:0] data, output int waits);
    @(posedge clock); #1;
    set_port(port, 1'b1, wren, addr, data);
    waits = 0;
    @(negedge clock);
    while (!(port ? p1_req_ready : p0_req_ready) && waits < 20) begin
      waits++;
      @(negedge clock);
    end
    if (waits >= 20) chk("req_timeout", waits, 0);
    @(posedge clock); #1;
    set_port(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    sb_q.delete();
    last0 = '0;
    last1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Reset state, with a request held valid that must not be accepted.
    p0_req_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_p0_ready", p0_req_ready, 1'b0);
    chk("rst_mem_en", {mem_rqvalid, mem_wren}, 2'b00);
    chk("rst_resp_valid", {p1_resp_valid, p0_resp_valid}, 2'b00);
    chk("rst_p0_data", p0_resp_data, 64'h0);
    chk("rst_p1_data", p1_resp_data, 64'h0);
    chk("rst_err", err_sticky, 1'b0);
    @(posedge clock); #1;
    p0_req_valid = 1'b0;
    reset = 1'b0;

    // Single write then read on port 0.
    do_req(1'b0, 1'b1, 10'd5, 64'hDEAD_BEEF, w);
    chk("single_wr_wait", w, 0);
    do_req(1'b0, 1'b0, 10'd5, '0, w);
    chk("single_rd_wait", w, 0);
    repeat (2) @(posedge clock);

    // Mixed traffic with rr_ptr=1: p1 read beats p0 write, p0 follows.
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, 1'b1, 10'd7, 64'hCAFE_0007);
    set_port(1'b1, 1'b1, 1'b0, 10'd5, '0);
    @(negedge clock);
    chk("mixed_first", {p1_req_ready, p0_req_ready}, 2'b10);
    @(posedge clock); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("mixed_second", {p1_req_ready, p0_req_ready}, 2'b01);
    @(posedge clock); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);

    // Contention: preload, reset, then both ports hold reads for 4 cycles.
    do_req(1'b0, 1'b1, 10'd1, 64'h1111_0000_AAAA_0001, w);
    do_req(1'b1, 1'b1, 10'd2, 64'h2222_0000_BBBB_0002, w);
    pulse_reset();
    set_port(1'b0, 1'b1, 1'b0, 10'd1, '0);
    set_port(1'b1, 1'b1, 1'b0, 10'd2, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("cont_grant%0d", i), {p1_req_ready, p0_req_ready},
          (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clock); #1;
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);

    // Back-to-back write then read of the top address on port 1.
    @(posedge clock); #1;
    set_port(1'b1, 1'b1, 1'b1, 10'd1023, 64'h1234);
    @(negedge clock);
    chk("hazard_wr_ready", p1_req_ready, 1'b1);
    @(posedge clock); #1;
    set_port(1'b1, 1'b1, 1'b0, 10'd1023, '0);
    @(negedge clock);
    chk("hazard_rd_ready", p1_req_ready, 1'b1);
    @(posedge clock); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("traffic_err", err_sticky, 1'b0);

    // Reset in the cycle after a read grant discards the pending response.
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, 1'b0, 10'd5, '0);
    @(negedge clock);
    chk("rstmid_ready", p0_req_ready, 1'b1);
    @(posedge clock); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    sb_q.delete();
    last0 = '0;
    last1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rstmid_err", err_sticky, 1'b0);
    chk("rstmid_p0_data", p0_resp_data, 64'h0);
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, 1'b0, 10'd1, '0);
    set_port(1'b1, 1'b1, 1'b0, 10'd2, '0);
    @(negedge clock);
    chk("rstmid_rr_ptr", {p1_req_ready, p0_req_ready}, 2'b01);
    @(posedge clock); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);

    // Anomaly: read data with nothing outstanding.
    @(posedge clock); #1;
    inj_rdvalid = 1'b1;
    @(posedge clock); #1;
    inj_rdvalid = 1'b0;
    @(negedge clock);
    chk("anom_err_set", err_sticky, 1'b1);
    repeat (3) @(negedge clock);
    chk("anom_err_hold", err_sticky, 1'b1);
    pulse_reset();
    @(negedge clock);
    chk("anom_err_clr", err_sticky, 1'b0);

    repeat (3) @(posedge clock);
    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
